// File: rtl/router_pkg.sv
// Shared definitions for the router packet source.
//   TX_DATA_W / TX_LEN_W : byte width and payload-length field width of the router protocol
//   ADDR_ILLEGAL         : destination code with no router output behind it
//   tx_state_t           : packet transmitter FSM encoding
//   pack_header()        : builds the header byte {payload_len, dest_addr}
package router_pkg;

  localparam int TX_DATA_W = 8;
  localparam int TX_LEN_W  = 6;
  localparam int TX_ADDR_W = 2;

  localparam logic [TX_ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_HEADER  = 3'd1,
    TX_PAYLOAD = 3'd2,
    TX_PARITY  = 3'd3,
    TX_GAP     = 3'd4
  } tx_state_t;

  function automatic logic [TX_DATA_W-1:0] pack_header(input logic [TX_LEN_W-1:0]  len,
                                                       input logic [TX_ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Show-ahead synchronous FIFO holding payload bytes for the packet source.
//   i_clk, i_rst    : clock, synchronous active-high reset (empties the buffer)
//   i_wr_en/i_wr_data : push; ignored while o_full
//   i_pop           : remove the head entry (caller guarantees non-empty)
//   o_head          : current head entry
//   o_head_nxt      : entry behind the head, so the caller can register it on a pop
//   o_full, o_count : status
module router_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic [DATA_W-1:0]          o_head_nxt,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign w_push     = i_wr_en & ~o_full;
  assign o_head     = r_mem[r_rd_ptr];
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign o_head_nxt = r_mem[r_rd_ptr + 1'b1];
  assign o_count    = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port. Payload bytes are buffered, then
// one packet is serialised as header, payload, parity (parity with pkt_valid low),
// followed by IDLE_GAP idle cycles. A byte is taken on a rising edge with busy=0.
//   clockr, resetr         : clock, synchronous active-high reset
//   wr_en, wr_data         : payload buffer push
//   buf_full, buf_count    : payload buffer status
//   start, dest_addr, payload_len, corrupt_parity : packet request (IDLE only)
//   busy                   : router stall
//   pkt_valid, data_out    : byte stream to the router
//   tx_active, done, req_err : transfer status
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W     = TX_DATA_W,
  parameter int LEN_W      = TX_LEN_W,
  parameter int FIFO_DEPTH = 64,
  parameter int IDLE_GAP   = 1
) (
  input  logic                          clockr,
  input  logic                          resetr,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          buf_full,
  output logic [$clog2(FIFO_DEPTH):0]   buf_count,
  input  logic                          start,
  input  logic [1:0]                    dest_addr,
  input  logic [LEN_W-1:0]              payload_len,
  input  logic                          corrupt_parity,
  input  logic                          busy,
  output logic                          pkt_valid,
  output logic [DATA_W-1:0]             data_out,
  output logic                          tx_active,
  output logic                          done,
  output logic                          req_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

  tx_state_t          r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_remain, w_remain_nxt;
  logic               r_corrupt, w_corrupt_nxt;
  logic [DATA_W-1:0]  r_parity, w_parity_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_pkt_valid, w_pkt_valid_nxt;
  logic [DATA_W-1:0]  r_data, w_data_nxt;
  logic               r_tx_active, w_tx_active_nxt;
  logic               r_done, w_done_nxt;
  logic               r_req_err, w_req_err_nxt;

  logic               w_pop;
  logic [DATA_W-1:0]  w_head;
  logic [DATA_W-1:0]  w_head_nxt;
  logic [DATA_W-1:0]  w_header;
  logic [DATA_W-1:0]  w_par_final;
  logic               w_start_ok;

  router_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clockr),
    .i_rst      (resetr),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_head_nxt (w_head_nxt),
    .o_full     (buf_full),
    .o_count    (buf_count)
  );

  assign w_header   = pack_header(payload_len, dest_addr);
  assign w_start_ok = (dest_addr != ADDR_ILLEGAL) && (payload_len != '0) &&
                      (buf_count >= CNT_W'(payload_len));
  // Accumulator including the byte currently being taken.
  assign w_par_final = r_parity ^ r_data;

  always_ff @(posedge clockr) begin
    if (resetr) begin
      r_state     <= TX_IDLE;
      r_remain    <= '0;
      r_corrupt   <= 1'b0;
      r_parity    <= '0;
      r_gap       <= '0;
      r_pkt_valid <= 1'b0;
      r_data      <= '0;
      r_tx_active <= 1'b0;
      r_done      <= 1'b0;
      r_req_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      r_corrupt   <= w_corrupt_nxt;
      r_parity    <= w_parity_nxt;
      r_gap       <= w_gap_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_data      <= w_data_nxt;
      r_tx_active <= w_tx_active_nxt;
      r_done      <= w_done_nxt;
      r_req_err   <= w_req_err_nxt;
    end
  end

  // Every output is loaded from its next-state value, so outputs reflect the
  // state being entered. While busy holds, the register values are kept.
  always_comb begin
    w_state_nxt     = r_state;
    w_remain_nxt    = r_remain;
    w_corrupt_nxt   = r_corrupt;
    w_parity_nxt    = r_parity;
    w_gap_nxt       = r_gap;
    w_pkt_valid_nxt = r_pkt_valid;
    w_data_nxt      = r_data;
    w_tx_active_nxt = r_tx_active;
    w_done_nxt      = 1'b0;
    w_req_err_nxt   = 1'b0;
    w_pop           = 1'b0;

    case (r_state)
      TX_IDLE: begin
        w_pkt_valid_nxt = 1'b0;
        w_data_nxt      = '0;
        w_tx_active_nxt = 1'b0;
        if (start) begin
          if (w_start_ok) begin
            w_state_nxt     = TX_HEADER;
            w_remain_nxt    = payload_len;
            w_corrupt_nxt   = corrupt_parity;
            w_parity_nxt    = w_header;
            w_pkt_valid_nxt = 1'b1;
            w_data_nxt      = w_header;
            w_tx_active_nxt = 1'b1;
          end else begin
            w_req_err_nxt = 1'b1;
          end
        end
      end

      TX_HEADER: begin
        if (!busy) begin
          w_state_nxt = TX_PAYLOAD;
          w_data_nxt  = w_head;
        end
      end

      TX_PAYLOAD: begin
        if (!busy) begin
          // The byte on data_out is the FIFO head; popping it exposes the
          // next one, which start-time length checking guarantees is present.
          w_pop        = 1'b1;
          w_parity_nxt = w_par_final;
          w_remain_nxt = r_remain - 1'b1;
          if (r_remain == LEN_W'(1)) begin
            w_state_nxt     = TX_PARITY;
            w_pkt_valid_nxt = 1'b0;
            w_data_nxt      = r_corrupt ? ~w_par_final : w_par_final;
          end else begin
            w_data_nxt = w_head_nxt;
          end
        end
      end

      TX_PARITY: begin
        if (!busy) begin
          w_state_nxt = TX_GAP;
          w_done_nxt  = 1'b1;
          w_data_nxt  = '0;
          w_gap_nxt   = GAP_W'(IDLE_GAP - 1);
        end
      end

      TX_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt     = TX_IDLE;
          w_tx_active_nxt = 1'b0;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end

      default: begin
        w_state_nxt = TX_IDLE;
      end
    endcase
  end

  assign pkt_valid = r_pkt_valid;
  assign data_out  = r_data;
  assign tx_active = r_tx_active;
  assign done      = r_done;
  assign req_err   = r_req_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

  logic       clockr;
  logic       resetr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       buf_full;
  logic [6:0] buf_count;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       corrupt_parity;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       req_err;

  int checks = 0;
  int errors = 0;

  // Per-cycle capture of the output stream; sample 0 is the cycle after start.
  logic       busy_sched [0:79];
  logic [7:0] cap_d      [0:79];
  logic       cap_v      [0:79];
  logic       cap_done   [0:79];
  logic       cap_act    [0:79];
  logic [6:0] cap_cnt    [0:79];

  router_pkt_tx dut (
    .clockr         (clockr),
    .resetr         (resetr),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .buf_full       (buf_full),
    .buf_count      (buf_count),
    .start          (start),
    .dest_addr      (dest_addr),
    .payload_len    (payload_len),
    .corrupt_parity (corrupt_parity),
    .busy           (busy),
    .pkt_valid      (pkt_valid),
    .data_out       (data_out),
    .tx_active      (tx_active),
    .done           (done),
    .req_err        (req_err)
  );

  initial begin
    clockr = 1'b0;
    forever #5 clockr = ~clockr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clockr);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 80; i++) busy_sched[i] = 1'b0;
  endtask

  // Records n cycles of outputs. busy_sched[c] is applied on the edge ending
  // the cycle of sample c-1 (sample 0's edge is the start edge).
  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      busy = busy_sched[c];
      tick();
      start       = 1'b0;
      cap_d[c]    = data_out;
      cap_v[c]    = pkt_valid;
      cap_done[c] = done;
      cap_act[c]  = tx_active;
      cap_cnt[c]  = buf_count;
    end
    busy = 1'b0;
  endtask

  task automatic test_reset();
    resetr = 1'b1;
    tick();
    tick();
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_pkt_valid got %b exp 0", pkt_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out got %h exp 00", data_out); end
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL rst_tx_active got %b exp 0", tx_active); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL rst_req_err got %b exp 0", req_err); end
    checks++; if (buf_count !== 7'd0) begin errors++; $display("FAIL rst_buf_count got %0d exp 0", buf_count); end
    checks++; if (buf_full !== 1'b0) begin errors++; $display("FAIL rst_buf_full got %b exp 0", buf_full); end
    resetr = 1'b0;
    tick();
  endtask

  // T1: header {3,1}=0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D.
  task automatic test_single();
    logic [7:0] ed [7];
    logic [6:0] ev, edn, ea;
    ed  = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00};
    ev  = 7'b0001111;
    edn = 7'b0100000;
    ea  = 7'b0111111;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    checks++; if (buf_count !== 7'd3) begin errors++; $display("FAIL t1_count_pre got %0d exp 3", buf_count); end
    clear_sched();
    start = 1'b1; dest_addr = 2'd1; payload_len = 6'd3; corrupt_parity = 1'b0;
    capture(7);
    for (int c = 0; c < 7; c++) begin
      checks++; if (cap_d[c] !== ed[c]) begin errors++; $display("FAIL t1_data[%0d] got %h exp %h", c, cap_d[c], ed[c]); end
      checks++; if (cap_v[c] !== ev[c]) begin errors++; $display("FAIL t1_valid[%0d] got %b exp %b", c, cap_v[c], ev[c]); end
      checks++; if (cap_done[c] !== edn[c]) begin errors++; $display("FAIL t1_done[%0d] got %b exp %b", c, cap_done[c], edn[c]); end
      checks++; if (cap_act[c] !== ea[c]) begin errors++; $display("FAIL t1_active[%0d] got %b exp %b", c, cap_act[c], ea[c]); end
    end
    checks++; if (cap_cnt[4] !== 7'd0) begin errors++; $display("FAIL t1_count_post got %0d exp 0", cap_cnt[4]); end
  endtask

  // T2: busy on two edges while 0x22 is presented: 0x22 visible three cycles.
  task automatic test_busy_stall();
    logic [7:0] ed [9];
    logic [8:0] ev, edn;
    ed  = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00};
    ev  = 9'b000111111;
    edn = 9'b010000000;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    clear_sched();
    busy_sched[3] = 1'b1;
    busy_sched[4] = 1'b1;
    start = 1'b1; dest_addr = 2'd1; payload_len = 6'd3; corrupt_parity = 1'b0;
    capture(9);
    for (int c = 0; c < 9; c++) begin
      checks++; if (cap_d[c] !== ed[c]) begin errors++; $display("FAIL t2_data[%0d] got %h exp %h", c, cap_d[c], ed[c]); end
      checks++; if (cap_v[c] !== ev[c]) begin errors++; $display("FAIL t2_valid[%0d] got %b exp %b", c, cap_v[c], ev[c]); end
      checks++; if (cap_done[c] !== edn[c]) begin errors++; $display("FAIL t2_done[%0d] got %b exp %b", c, cap_done[c], edn[c]); end
    end
  endtask

  // T3: illegal requests, then drain the two bytes: header {2,0}=0x08, parity 0x08^0x44^0x55=0x19.
  task automatic test_req_err();
    logic [1:0] ra [3];
    logic [5:0] rl [3];
    logic [7:0] ed [6];
    logic [5:0] ev, edn;
    ra = '{2'd3, 2'd0, 2'd0};
    rl = '{6'd1, 6'd0, 6'd5};
    push_byte(8'h44); push_byte(8'h55);
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; dest_addr = ra[k]; payload_len = rl[k]; corrupt_parity = 1'b0;
      tick();
      start = 1'b0;
      checks++; if (req_err !== 1'b1) begin errors++; $display("FAIL t3_req_err[%0d] got %b exp 1", k, req_err); end
      checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL t3_valid[%0d] got %b exp 0", k, pkt_valid); end
      checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL t3_active[%0d] got %b exp 0", k, tx_active); end
      checks++; if (buf_count !== 7'd2) begin errors++; $display("FAIL t3_count[%0d] got %0d exp 2", k, buf_count); end
      tick();
      checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL t3_req_err_pulse[%0d] got %b exp 0", k, req_err); end
    end
    ed  = '{8'h08, 8'h44, 8'h55, 8'h19, 8'h00, 8'h00};
    ev  = 6'b000111;
    edn = 6'b010000;
    clear_sched();
    start = 1'b1; dest_addr = 2'd0; payload_len = 6'd2;
    capture(6);
    for (int c = 0; c < 6; c++) begin
      checks++; if (cap_d[c] !== ed[c]) begin errors++; $display("FAIL t3_data[%0d] got %h exp %h", c, cap_d[c], ed[c]); end
      checks++; if (cap_v[c] !== ev[c]) begin errors++; $display("FAIL t3_pvalid[%0d] got %b exp %b", c, cap_v[c], ev[c]); end
      checks++; if (cap_done[c] !== edn[c]) begin errors++; $display("FAIL t3_done[%0d] got %b exp %b", c, cap_done[c], edn[c]); end
    end
  endtask

  // T4: header {1,2}=0x06; 0x06^0xA5=0xA3, injected parity ~0xA3=0x5C.
  task automatic test_corrupt_parity();
    logic [7:0] ed [5];
    logic [4:0] ev;
    ev = 5'b00011;
    for (int k = 0; k < 2; k++) begin
      ed = '{8'h06, 8'hA5, (k == 0) ? 8'h5C : 8'hA3, 8'h00, 8'h00};
      push_byte(8'hA5);
      clear_sched();
      start = 1'b1; dest_addr = 2'd2; payload_len = 6'd1; corrupt_parity = (k == 0);
      capture(5);
      corrupt_parity = 1'b0;
      for (int c = 0; c < 5; c++) begin
        checks++; if (cap_d[c] !== ed[c]) begin errors++; $display("FAIL t4_data[%0d][%0d] got %h exp %h", k, c, cap_d[c], ed[c]); end
        checks++; if (cap_v[c] !== ev[c]) begin errors++; $display("FAIL t4_valid[%0d][%0d] got %b exp %b", k, c, cap_v[c], ev[c]); end
      end
      checks++; if (cap_done[3] !== 1'b1) begin errors++; $display("FAIL t4_done[%0d] got %b exp 1", k, cap_done[3]); end
    end
  endtask

  // T5: reset mid-payload, then header {2,1}=0x09, parity 0x09^0x7E^0x81=0xF6.
  task automatic test_reset_midpacket();
    logic [7:0] ed [6];
    logic [5:0] ev;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    clear_sched();
    start = 1'b1; dest_addr = 2'd0; payload_len = 6'd4;
    capture(3);
    checks++; if (cap_d[2] !== 8'h02) begin errors++; $display("FAIL t5_pre_data got %h exp 02", cap_d[2]); end
    resetr = 1'b1;
    tick();
    resetr = 1'b0;
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %b exp 0", pkt_valid); end
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL t5_active got %b exp 0", tx_active); end
    checks++; if (buf_count !== 7'd0) begin errors++; $display("FAIL t5_count got %0d exp 0", buf_count); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL t5_data got %h exp 00", data_out); end
    push_byte(8'h7E); push_byte(8'h81);
    ed = '{8'h09, 8'h7E, 8'h81, 8'hF6, 8'h00, 8'h00};
    ev = 6'b000111;
    start = 1'b1; dest_addr = 2'd1; payload_len = 6'd2;
    capture(6);
    for (int c = 0; c < 6; c++) begin
      checks++; if (cap_d[c] !== ed[c]) begin errors++; $display("FAIL t5_post_data[%0d] got %h exp %h", c, cap_d[c], ed[c]); end
      checks++; if (cap_v[c] !== ev[c]) begin errors++; $display("FAIL t5_post_valid[%0d] got %b exp %b", c, cap_v[c], ev[c]); end
    end
  endtask

  // T6: 63-byte packet (payload 1..63, header {63,2}=0xFE, XOR 1..63 = 0 so
  // parity 0xFE) with an extra 0x40 behind it and 0xC3 pushed every cycle.
  task automatic test_max_len();
    logic [7:0] ed [5];
    for (int i = 1; i <= 63; i++) push_byte(8'(i));
    push_byte(8'h40);
    checks++; if (buf_full !== 1'b1) begin errors++; $display("FAIL t6_full got %b exp 1", buf_full); end
    push_byte(8'hEE);
    checks++; if (buf_count !== 7'd64) begin errors++; $display("FAIL t6_drop_count got %0d exp 64", buf_count); end
    clear_sched();
    wr_en = 1'b1; wr_data = 8'hC3;
    start = 1'b1; dest_addr = 2'd2; payload_len = 6'd63;
    capture(67);
    wr_en = 1'b0;
    checks++; if (cap_d[0] !== 8'hFE) begin errors++; $display("FAIL t6_header got %h exp fe", cap_d[0]); end
    for (int c = 1; c <= 63; c++) begin
      checks++; if (cap_d[c] !== 8'(c)) begin errors++; $display("FAIL t6_data[%0d] got %h exp %h", c, cap_d[c], 8'(c)); end
      checks++; if (cap_v[c] !== 1'b1) begin errors++; $display("FAIL t6_valid[%0d] got %b exp 1", c, cap_v[c]); end
    end
    checks++; if (cap_d[64] !== 8'hFE) begin errors++; $display("FAIL t6_parity got %h exp fe", cap_d[64]); end
    checks++; if (cap_v[64] !== 1'b0) begin errors++; $display("FAIL t6_parity_valid got %b exp 0", cap_v[64]); end
    checks++; if (cap_cnt[64] !== 7'd63) begin errors++; $display("FAIL t6_count_mid got %0d exp 63", cap_cnt[64]); end
    checks++; if (cap_done[65] !== 1'b1) begin errors++; $display("FAIL t6_done got %b exp 1", cap_done[65]); end
    checks++; if (buf_count !== 7'd64) begin errors++; $display("FAIL t6_count_end got %0d exp 64", buf_count); end
    // Head of the buffer must be the byte queued behind the packet.
    ed = '{8'h04, 8'h40, 8'h44, 8'h00, 8'h00};
    clear_sched();
    start = 1'b1; dest_addr = 2'd0; payload_len = 6'd1;
    capture(5);
    for (int c = 0; c < 5; c++) begin
      checks++; if (cap_d[c] !== ed[c]) begin errors++; $display("FAIL t6_next_data[%0d] got %h exp %h", c, cap_d[c], ed[c]); end
    end
    checks++; if (buf_count !== 7'd63) begin errors++; $display("FAIL t6_count_final got %0d exp 63", buf_count); end
  endtask

  initial begin
    resetr         = 1'b1;
    wr_en          = 1'b0;
    wr_data        = 8'h00;
    start          = 1'b0;
    dest_addr      = 2'd0;
    payload_len    = 6'd0;
    corrupt_parity = 1'b0;
    busy           = 1'b0;
    test_reset();
    test_single();
    test_busy_stall();
    test_req_err();
    test_corrupt_parity();
    test_reset_midpacket();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
